// File: rtl/msg_bit_packer_pkg.sv
// Shared definitions for the message bit packer: state encoding, default sizes
// and the FIFO entry layout.
package msg_bit_packer_pkg;

  localparam int unsigned DefOutW  = 8;
  localparam int unsigned DefNbW   = 4;
  localparam int unsigned DefDepth = 4;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StFlush   = 2'd2;

  // FIFO entry layout, MSB to LSB: {last, nbits[NB_W-1:0], data[OUT_W-1:0]}
  function automatic int unsigned entry_w(input int unsigned out_w, input int unsigned nb_w);
    return out_w + nb_w + 1;
  endfunction

endpackage

// File: rtl/msg_bit_packer_if.sv
// Packed-word output stream of the message bit packer (valid/ready).
interface msg_bit_packer_if
  import msg_bit_packer_pkg::*;
#(
  parameter int unsigned OUT_W = DefOutW,
  parameter int unsigned NB_W  = DefNbW
);
  logic [OUT_W-1:0] out_data;
  logic [NB_W-1:0]  out_nbits;
  logic             out_last;
  logic             out_vld;
  logic             out_rdy;

  modport master (output out_data, out_nbits, out_last, out_vld, input out_rdy);
  modport slave  (input out_data, out_nbits, out_last, out_vld, output out_rdy);
endinterface

// File: rtl/msg_word_fifo.sv
// Generic synchronous show-ahead FIFO; head data reads as 0 while empty.
module msg_word_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/msg_bit_packer.sv
// Packs decoder message bits MSB-first into words and closes each message with a
// left-aligned last word. Optional bit counter: define MSG_PACK_BITCNT_EN.
module msg_bit_packer
  import msg_bit_packer_pkg::*;
#(
  parameter int unsigned OUT_W = DefOutW,
  parameter int unsigned NB_W  = DefNbW,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             msg_done,
  msg_bit_packer_if.master out_if,
  output logic             busy,
  output logic             overflow
`ifdef MSG_PACK_BITCNT_EN
  ,
  output logic [15:0]      msg_bits
`endif
);

  localparam int unsigned EntryW = OUT_W + NB_W + 1;

  logic [1:0]        state_q, state_d;
  logic [OUT_W-1:0]  shift_q, shift_d;
  logic [NB_W-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, can_push, fifo_full, fifo_empty;
  logic [EntryW-1:0] push_entry, head;
  logic [OUT_W-1:0]  shifted, flush_data;

  assign shifted    = {shift_q[OUT_W-2:0], bit_in};
  assign flush_data = (cnt_q == '0) ? '0 : (shift_q << (NB_W'(OUT_W) - cnt_q));
  assign pop        = out_if.out_vld && out_if.out_rdy;
  assign can_push   = !fifo_full || pop;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          shift_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (bit_vld) begin
          shift_d = shifted;
          if (cnt_q == NB_W'(OUT_W - 1)) begin
            cnt_d      = '0;
            push       = 1'b1;
            push_entry = {1'b0, NB_W'(OUT_W), shifted};
            if (!can_push) ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + NB_W'(1);
          end
        end
        if (msg_done) state_d = StFlush;
      end
      StFlush: begin
        // Hold here until the last word fits; it is never dropped.
        push       = 1'b1;
        push_entry = {1'b1, cnt_q, flush_data};
        if (can_push) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  msg_word_fifo #(
    .WIDTH(EntryW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk  (clk),
    .rst_b(rst_b),
    .push (push),
    .wdata(push_entry),
    .pop  (pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign out_if.out_data  = head[OUT_W-1:0];
  assign out_if.out_nbits = head[EntryW-2 -: NB_W];
  assign out_if.out_last  = head[EntryW-1];
  assign out_if.out_vld   = !fifo_empty;
  assign busy             = (state_q != StIdle);
  assign overflow         = ovf_q;

`ifdef MSG_PACK_BITCNT_EN
  logic [15:0] bits_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bits_q <= '0;
    end else if (state_q == StIdle && start) begin
      bits_q <= '0;
    end else if (state_q == StCollect && bit_vld && bits_q != 16'hFFFF) begin
      bits_q <= bits_q + 16'd1;
    end
  end

  assign msg_bits = bits_q;
`endif

endmodule

// File: tb/tb_msg_bit_packer.sv
// Self-checking bench for msg_bit_packer: random messages against a queue-based model.
module tb_msg_bit_packer;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic start = 1'b0, bit_in = 1'b0, bit_vld = 1'b0, msg_done = 1'b0;
  logic busy, overflow;
`ifdef MSG_PACK_BITCNT_EN
  logic [15:0] msg_bits;
`endif

  msg_bit_packer_if #(.OUT_W(8), .NB_W(4)) out_if ();

  msg_bit_packer #(.OUT_W(8), .NB_W(4), .DEPTH(4), .AW(2)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .start   (start),
    .bit_in  (bit_in),
    .bit_vld (bit_vld),
    .msg_done(msg_done),
    .out_if  (out_if.master),
    .busy    (busy),
    .overflow(overflow)
`ifdef MSG_PACK_BITCNT_EN
    ,
    .msg_bits(msg_bits)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [12:0] got_q[$];
  logic [12:0] exp_q[$];
  bit          bits_q[$];

  // Words accepted by the consumer, captured between edges.
  always @(negedge clk) begin
    if (rst_b && out_if.out_vld && out_if.out_rdy)
      got_q.push_back({out_if.out_last, out_if.out_nbits, out_if.out_data});
  end

  task automatic cyc(input logic s, input logic v, input logic b, input logic d);
    start = s; bit_vld = v; bit_in = b; msg_done = d;
    @(posedge clk); #1;
    start = 1'b0; bit_vld = 1'b0; msg_done = 1'b0;
  endtask

  // Reference: chop the message into 8-bit MSB-first words, then a left-aligned
  // last word holding the remainder (terminator when nothing remains).
  task automatic model_msg();
    int n = bits_q.size();
    int k = 0;
    logic [7:0] w;
    while (n - k >= 8) begin
      w = '0;
      for (int j = 0; j < 8; j++) w[7-j] = bits_q[k+j];
      exp_q.push_back({1'b0, 4'd8, w});
      k += 8;
    end
    w = '0;
    for (int j = 0; j < n - k; j++) w[7-j] = bits_q[k+j];
    exp_q.push_back({1'b1, 4'(n - k), w});
  endtask

  task automatic send_bits(input int len, input int gap_max, input bit merge_done);
    bit b;
    for (int i = 0; i < len; i++) begin
      b = 1'($urandom);
      bits_q.push_back(b);
      repeat ($urandom_range(gap_max, 0)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, b, merge_done && (i == len - 1));
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy && !out_if.out_vld) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({out_if.out_vld, out_if.out_data, out_if.out_nbits, out_if.out_last, busy, overflow}
        !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: vld=%b data=%h nbits=%0d last=%b busy=%b ovf=%b, want all 0",
               out_if.out_vld, out_if.out_data, out_if.out_nbits, out_if.out_last, busy,
               overflow);
    end
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_packing();
    bit ok;
    bit pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    out_if.out_rdy = 1'b1;
    got_q = {}; exp_q = {};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    foreach (pat[i]) cyc(1'b0, 1'b1, pat[i], 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL pack_busy_flush: got %b want 1", busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL pack_busy_idle: got %b want 0", busy);
    end
    wait_drain(ok);
    exp_q = '{{1'b0, 4'd8, 8'hB2}, {1'b1, 4'd0, 8'h00}};
    n_cmp++;
    if (!ok || got_q.size() != 2) begin
      n_bad++; $display("FAIL pack_count: got %0d words want 2 (drained=%b)", got_q.size(), ok);
    end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL pack_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    // Random messages, random bit gaps, consumer always ready.
    for (int m = 0; m < 6; m++) begin
      int len = $urandom_range(27, 0);
      got_q = {}; exp_q = {}; bits_q = {};
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      send_bits(len, 2, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      wait_drain(ok);
      model_msg();
      n_cmp++;
      if (!ok || got_q.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL rand_count msg%0d: got %0d words want %0d (drained=%b)", m,
                 got_q.size(), exp_q.size(), ok);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL rand_word msg%0d.%0d: got %h want %h", m, i, got_q[i], exp_q[i]);
        end
      end
`ifdef MSG_PACK_BITCNT_EN
      n_cmp++;
      if (msg_bits !== 16'(len)) begin
        n_bad++; $display("FAIL rand_msg_bits msg%0d: got %0d want %0d", m, msg_bits, len);
      end
`endif
    end
  endtask

  task automatic test_partial();
    bit ok;
    out_if.out_rdy = 1'b0;
    got_q = {};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({out_if.out_vld, out_if.out_last, out_if.out_nbits, out_if.out_data} !== {2'b10, 4'd8, 8'hFF})
    begin
      n_bad++;
      $display("FAIL partial_latency: vld=%b last=%b nbits=%0d data=%h want 1/0/8/ff",
               out_if.out_vld, out_if.out_last, out_if.out_nbits, out_if.out_data);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    out_if.out_rdy = 1'b1;
    wait_drain(ok);
    exp_q = '{{1'b0, 4'd8, 8'hFF}, {1'b1, 4'd3, 8'hA0}};
    n_cmp++;
    if (!ok || got_q.size() != 2) begin
      n_bad++; $display("FAIL partial_count: got %0d words want 2 (drained=%b)", got_q.size(), ok);
    end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL partial_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    out_if.out_rdy = 1'b1;
    got_q = {}; exp_q = {}; bits_q = {};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8, 0, 1'b1);
    wait_drain(ok);
    model_msg();
    n_cmp++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL same_cycle_count: got %0d want %0d (drained=%b)", got_q.size(),
               exp_q.size(), ok);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL same_cycle_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    out_if.out_rdy = 1'b0;
    got_q = {}; exp_q = {}; bits_q = {};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(43, 0, 1'b0);
    n_cmp++;
    if ({overflow, out_if.out_vld} !== 2'b11) begin
      n_bad++; $display("FAIL bp_overflow: ovf=%b vld=%b want 1/1", overflow, out_if.out_vld);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL bp_flush_wait: busy=%b want 1", busy);
    end
    out_if.out_rdy = 1'b1;
    wait_drain(ok);
    model_msg();
    exp_q.delete(4);
    n_cmp++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL bp_count: got %0d want %0d (drained=%b)", got_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++; $display("FAIL bp_overflow_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    bit ok;
    bit b;
    out_if.out_rdy = 1'b0;
    got_q = {}; exp_q = {}; bits_q = {};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL start_clears_overflow: got %b want 0", overflow);
    end
    send_bits(39, 0, 1'b0);
    out_if.out_rdy = 1'b1;
    b = 1'($urandom);
    bits_q.push_back(b);
    cyc(1'b0, 1'b1, b, 1'b1);
    wait_drain(ok);
    model_msg();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL full_push_pop_ovf: got %b want 0", overflow);
    end
    n_cmp++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL full_push_pop_count: got %0d want %0d (drained=%b)", got_q.size(),
               exp_q.size(), ok);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL full_push_pop_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ignored();
    bit ok;
    bit b;
    out_if.out_rdy = 1'b1;
    got_q = {}; exp_q = {}; bits_q = {};
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({busy, out_if.out_vld} !== 2'b00) begin
      n_bad++; $display("FAIL idle_ignores: busy=%b vld=%b want 0/0", busy, out_if.out_vld);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(3, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(4, 0, 1'b0);
    b = 1'($urandom);
    bits_q.push_back(b);
    cyc(1'b1, 1'b1, b, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain(ok);
    model_msg();
    n_cmp++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL ignored_count: got %0d want %0d (drained=%b)", got_q.size(),
               exp_q.size(), ok);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL ignored_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
`ifdef MSG_PACK_BITCNT_EN
    n_cmp++;
    if (msg_bits !== 16'd8) begin
      n_bad++; $display("FAIL ignored_msg_bits: got %0d want 8", msg_bits);
    end
`endif
  endtask

  task automatic test_reset_mid();
    out_if.out_rdy = 1'b0;
    bits_q = {};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(21, 0, 1'b0);
    n_cmp++;
    if ({busy, out_if.out_vld} !== 2'b11) begin
      n_bad++; $display("FAIL mid_before: busy=%b vld=%b want 1/1", busy, out_if.out_vld);
    end
    #2 rst_b = 1'b0;
    #1;
    n_cmp++;
    if ({out_if.out_vld, overflow, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_reset: vld=%b ovf=%b busy=%b want 0/0/0", out_if.out_vld, overflow, busy);
    end
`ifdef MSG_PACK_BITCNT_EN
    n_cmp++;
    if (msg_bits !== 16'd0) begin
      n_bad++; $display("FAIL mid_reset_msg_bits: got %0d want 0", msg_bits);
    end
`endif
    @(negedge clk) rst_b = 1'b1;
    out_if.out_rdy = 1'b1;
    got_q = {};
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++; $display("FAIL mid_discard: got %0d words want 0", got_q.size());
    end
  endtask

  initial begin
    out_if.out_rdy = 1'b0;
    test_reset();
    test_packing();
    test_partial();
    test_same_cycle();
    test_backpressure();
    test_full_push_pop();
    test_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
